// File: rtl/range_gate_overlap_framer_pkg.sv
// Shared types for the range-gate overlap framer.
//   state_t : framer FSM states
//   cfg_t   : run-time configuration latched on start
//   ptr_w() : ring pointer width (address bits plus one wrap bit)
package range_gate_overlap_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        READ,
        PAD
    } state_t;

    // Gate-width fields are widened to 16 bits so the struct does not
    // depend on the instance's GATE_W.
    typedef struct packed {
        logic [15:0] skip_bursts;
        logic [15:0] gate_len;
        logic [15:0] overlap_len;
        logic [15:0] n_gates;
    } cfg_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/range_gate_overlap_framer_sdp_ram.sv
// Simple dual-port RAM for the framer's sample ring buffer.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read port, rd_data registered (1-cycle latency)
module rgof_sdp_ram #(
    parameter int unsigned BIT_WIDTH = 14,
    parameter int unsigned DEPTH     = 8192,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [BIT_WIDTH-1:0] rd_data
);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/range_gate_overlap_framer.sv
// Range-gate overlap framer: buffers one trigger of ADC samples in a ring
// buffer and emits NFFT-beat frames of gate_len samples (zero padded) with
// run-time overlap between consecutive gates.
//   clk, rst                : clock, asynchronous active-low reset
//   start                   : latch config, flush, begin acquisition
//   din, din_valid          : ADC sample stream (bursts)
//   skip_bursts             : bursts ignored after start
//   gate_len, overlap_len   : gate size and overlap in samples
//   n_gates                 : frames per trigger
//   dout*, dout_ready       : frame stream with SOP/EOP/gate sideband
//   busy, overflow, cfg_err : status
module range_gate_overlap_framer
    import range_gate_overlap_framer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 14,
    parameter int unsigned NFFT      = 1024,
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned GATE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic [GATE_W-1:0]    skip_bursts,
    input  logic [15:0]          gate_len,
    input  logic [15:0]          overlap_len,
    input  logic [GATE_W-1:0]    n_gates,
    output logic [BIT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_sop,
    output logic                 dout_eop,
    output logic [GATE_W-1:0]    dout_gate,
    output logic                 busy,
    output logic                 overflow,
    output logic                 cfg_err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = ptr_w(DEPTH);
    localparam int unsigned BW   = $clog2(NFFT);
    localparam int unsigned WC_W = $clog2(NFFT) + GATE_W + 1;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] data;
        logic                 sop;
        logic                 eop;
        logic [GATE_W-1:0]    gate;
    } beat_t;

    typedef struct packed {
        logic              is_data;
        logic              sop;
        logic              eop;
        logic [GATE_W-1:0] gate;
    } meta_t;

    state_t              state;
    cfg_t                cfg;
    cfg_t                cfg_in;
    logic [15:0]         step;
    logic [WC_W-1:0]     total;
    logic [PW-1:0]       wp, fb, rp;
    logic [WC_W-1:0]     wr_cnt;
    logic [GATE_W-1:0]   gate;
    logic [BW-1:0]       bcnt;
    logic                acq;
    logic                cfg_err_r;

    logic                din_valid_q;
    logic [GATE_W-1:0]   burst_cnt;
    logic                in_valid_r;
    logic [BIT_WIDTH-1:0] in_data_r;
    logic                overflow_r;

    logic                s1_valid;
    meta_t               s1_meta;
    beat_t               slot0, slot1, push_beat;
    logic [1:0]          cnt, cnt_after_pop;
    logic [BIT_WIDTH-1:0] ram_q;

    logic [15:0]         cfg_step;
    logic [31:0]         total_calc;
    logic                cfg_bad;
    logic [PW-1:0]       occ, fb_next, occ_next;
    logic                full, will_write, capture, fell;
    logic                issue, room, pop, last_beat, last_data, avail_next;

    assign cfg_in = '{skip_bursts: 16'(skip_bursts), gate_len: gate_len,
                      overlap_len: overlap_len, n_gates: 16'(n_gates)};

    assign cfg_step   = cfg.gate_len - cfg.overlap_len;
    assign total_calc = (32'(cfg.n_gates) - 32'd1) * 32'(cfg_step) + 32'(cfg.gate_len);
    assign cfg_bad    = (cfg.gate_len == '0) || (32'(cfg.gate_len) > NFFT) ||
                        (cfg.overlap_len >= cfg.gate_len);

    assign occ        = wp - fb;
    assign fb_next    = fb + PW'(step);
    assign occ_next   = wp - fb_next;
    assign full       = (occ == PW'(DEPTH));
    assign avail_next = 32'(occ_next) >= 32'(cfg.gate_len);

    // ---------------- input side ----------------
    assign fell       = din_valid_q & ~din_valid;
    assign will_write = in_valid_r & ~full;
    // Stop capturing once the samples for every gate are accounted for;
    // a pending dropped sample does not count towards the total.
    assign capture    = acq && din_valid && (16'(burst_cnt) >= cfg.skip_bursts) &&
                        ((wr_cnt + WC_W'(will_write)) < total);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_valid_q <= 1'b0;
            burst_cnt   <= '0;
            in_valid_r  <= 1'b0;
            in_data_r   <= '0;
            wp          <= '0;
            wr_cnt      <= '0;
            overflow_r  <= 1'b0;
        end else begin
            din_valid_q <= din_valid;
            if (start) begin
                burst_cnt  <= '0;
                in_valid_r <= 1'b0;
                wp         <= '0;
                wr_cnt     <= '0;
                overflow_r <= 1'b0;
            end else begin
                if (fell && (burst_cnt != '1)) burst_cnt <= burst_cnt + GATE_W'(1);
                in_valid_r <= capture;
                if (capture) in_data_r <= din;
                if (in_valid_r) begin
                    if (full) begin
                        overflow_r <= 1'b1;
                    end else begin
                        wp     <= wp + PW'(1);
                        wr_cnt <= wr_cnt + WC_W'(1);
                    end
                end
            end
        end
    end

    rgof_sdp_ram #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (will_write),
        .wr_addr (wp[AW-1:0]),
        .wr_data (in_data_r),
        .rd_en   (issue && (state == READ)),
        .rd_addr (rp[AW-1:0]),
        .rd_data (ram_q)
    );

    // ---------------- frame sequencer ----------------
    assign pop           = dout_valid & dout_ready;
    assign cnt_after_pop = cnt - {1'b0, pop};
    // Issue only if the beat in flight plus this one still fit the skid.
    assign room          = (cnt_after_pop + {1'b0, s1_valid}) <= 2'd1;
    assign issue         = room && ((state == READ) || (state == PAD));
    assign last_beat     = (bcnt == BW'(NFFT - 1));
    assign last_data     = 32'(bcnt) == (32'(cfg.gate_len) - 32'd1);

    // The frame is retired when its last beat is issued rather than when it
    // is accepted: all its RAM reads are done by then, and this lets the next
    // frame start without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cfg       <= '0;
            step      <= '0;
            total     <= '0;
            fb        <= '0;
            rp        <= '0;
            gate      <= '0;
            bcnt      <= '0;
            acq       <= 1'b0;
            cfg_err_r <= 1'b0;
        end else if (start) begin
            state <= CHECK;
            cfg   <= cfg_in;
            fb    <= '0;
            rp    <= '0;
            gate  <= '0;
            bcnt  <= '0;
            acq   <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                CHECK: begin
                    step  <= cfg_step;
                    total <= WC_W'(total_calc);
                    if (cfg_bad) begin
                        cfg_err_r <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cfg_err_r <= 1'b0;
                        if (cfg.n_gates == '0) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT;
                            acq   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (32'(occ) >= 32'(cfg.gate_len)) begin
                        state <= READ;
                        rp    <= fb;
                        bcnt  <= '0;
                    end
                end
                READ, PAD: begin
                    if (issue) begin
                        bcnt <= bcnt + BW'(1);
                        if (state == READ) begin
                            rp <= rp + PW'(1);
                            if (last_data) state <= PAD;
                        end
                        if (last_beat) begin
                            bcnt <= '0;
                            fb   <= fb_next;
                            gate <= gate + GATE_W'(1);
                            if (16'(gate) + 16'd1 == cfg.n_gates) begin
                                state <= IDLE;
                                acq   <= 1'b0;
                            end else if (avail_next) begin
                                state <= READ;
                                rp    <= fb_next;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- output path: read stage + 2-entry skid ----------------
    assign push_beat = '{data: s1_meta.is_data ? ram_q : '0, sop: s1_meta.sop,
                         eop: s1_meta.eop, gate: s1_meta.gate};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_meta  <= '0;
            slot0    <= '0;
            slot1    <= '0;
            cnt      <= '0;
        end else if (start) begin
            s1_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_meta <= '{is_data: (state == READ), sop: (bcnt == '0),
                             eop: last_beat, gate: gate};
            end
            if (pop) slot0 <= slot1;
            if (s1_valid) begin
                if (cnt_after_pop == 2'd0) slot0 <= push_beat;
                else                       slot1 <= push_beat;
            end
            cnt <= cnt_after_pop + {1'b0, s1_valid};
        end
    end

    assign dout_valid = (cnt != 2'd0);
    assign dout       = dout_valid ? slot0.data : '0;
    assign dout_sop   = dout_valid & slot0.sop;
    assign dout_eop   = dout_valid & slot0.eop;
    assign dout_gate  = dout_valid ? slot0.gate : '0;
    assign busy       = (state != IDLE) || s1_valid || dout_valid;
    assign overflow   = overflow_r;
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_range_gate_overlap_framer.sv
module tb_range_gate_overlap_framer;

    localparam int NFFT   = 1024;
    localparam int BUDGET = 30000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [13:0] din = '0;
    logic        din_valid = 1'b0;
    logic [7:0]  skip_bursts = '0;
    logic [15:0] gate_len = '0;
    logic [15:0] overlap_len = '0;
    logic [7:0]  n_gates = '0;
    logic [13:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_sop;
    logic        dout_eop;
    logic [7:0]  dout_gate;
    logic        busy;
    logic        overflow;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;
    int span = 0;

    range_gate_overlap_framer #(
        .BIT_WIDTH (14),
        .NFFT      (NFFT),
        .DEPTH     (8192),
        .GATE_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .din         (din),
        .din_valid   (din_valid),
        .skip_bursts (skip_bursts),
        .gate_len    (gate_len),
        .overlap_len (overlap_len),
        .n_gates     (n_gates),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .dout_gate   (dout_gate),
        .busy        (busy),
        .overflow    (overflow),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return 32'({dout_valid, dout, dout_sop, dout_eop, dout_gate});
    endfunction

    function automatic logic [31:0] all_outputs();
        return 32'({dout_valid, dout, dout_sop, dout_eop, dout_gate, busy, overflow, cfg_err});
    endfunction

    function automatic logic [31:0] exp_word(input int idx, input int base, input int stp, input int glen);
        int k, b;
        logic [13:0] data;
        k = idx / NFFT;
        b = idx % NFFT;
        data = (b < glen) ? 14'(base + k * stp + b) : 14'd0;
        return 32'({1'b1, data, (b == 0), (b == NFFT - 1), 8'(k)});
    endfunction

    task automatic set_cfg(input int glen, input int ovl, input int ng, input int skip);
        gate_len    = 16'(glen);
        overlap_len = 16'(ovl);
        n_gates     = 8'(ng);
        skip_bursts = 8'(skip);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_bursts(input int nb, input int len, input int gap, input int first);
        int v;
        v = first;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                din       = 14'(v);
                din_valid = 1'b1;
                v++;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
        end
    endtask

    // Accepts 'beats' beats, checking each against the frame model and
    // checking that a stalled beat is held unchanged.
    task automatic consume(input int beats, input int base, input int stp, input int glen,
                           input bit rand_ready);
        int idx, cyc, first_cyc, last_cyc;
        bit hold;
        logic [31:0] held;
        idx = 0; cyc = 0; first_cyc = -1; last_cyc = 0; hold = 1'b0; held = '0;
        while (idx < beats && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (hold) check_eq("stall_stable", out_word(), held);
            dout_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            hold = 1'b0;
            if (dout_valid) begin
                if (dout_ready) begin
                    check_eq("beat", out_word(), exp_word(idx, base, stp, glen));
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    idx++;
                end else begin
                    hold = 1'b1;
                    held = out_word();
                end
            end
        end
        if (idx < beats) check_eq("consume_timeout", 32'(idx), 32'(beats));
        span = last_cyc - first_cyc + 1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ill_g[3];
        int ill_o[3];
        bit seen;
        ill_g = '{0, 1025, 300};
        ill_o = '{0, 0, 300};

        // reset state
        #3;
        check_eq("reset_outputs", all_outputs(), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: 4 overlapping gates after skipping 2 bursts, ready held high
        set_cfg(256, 128, 4, 2);
        do_start();
        check_eq("t1_busy_after_start", 32'(busy), 32'd1);
        fork
            drive_bursts(4, 600, 8, 0);
            consume(4 * NFFT, 1200, 128, 256, 1'b0);
        join
        @(negedge clk);
        check_eq("t1_idle_after_last", 32'({busy, dout_valid, overflow, cfg_err}), 32'd0);

        // 2: same config, random backpressure
        do_start();
        fork
            drive_bursts(4, 600, 8, 0);
            consume(4 * NFFT, 1200, 128, 256, 1'b1);
        join
        @(negedge clk);
        check_eq("t2_busy_done", 32'(busy), 32'd0);

        // 3: fill the ring exactly, then one more sample overflows
        set_cfg(1024, 0, 9, 0);
        do_start();
        drive_bursts(1, 8192, 4, 0);
        check_eq("t3_no_ovf_at_full", 32'(overflow), 32'd0);
        drive_bursts(1, 1, 4, 8192);
        check_eq("t3_ovf_on_8193", 32'(overflow), 32'd1);
        consume(8 * NFFT, 0, 1024, 1024, 1'b0);
        check_eq("t3_no_bubbles", 32'(span), 32'(8 * NFFT));
        check_eq("t3_gate8_pending", 32'(busy), 32'd1);

        // 4: illegal configurations, then legal with n_gates = 0
        for (int i = 0; i < 3; i++) begin
            set_cfg(ill_g[i], ill_o[i], 4, 0);
            do_start();
            repeat (2) @(negedge clk);
            check_eq("t4_illegal_status", 32'({cfg_err, busy, dout_valid, overflow}), 32'b1000);
        end
        set_cfg(256, 128, 0, 0);
        do_start();
        repeat (2) @(negedge clk);
        check_eq("t4_zero_gates", 32'({cfg_err, busy, dout_valid}), 32'd0);

        // 5: abort mid frame 2
        set_cfg(256, 128, 4, 2);
        do_start();
        check_eq("t5_cfg_err_cleared", 32'(cfg_err), 32'd0);
        fork
            drive_bursts(4, 600, 8, 0);
            consume(2 * NFFT + 100, 1200, 128, 256, 1'b0);
        join
        check_eq("t5_valid_before_abort", 32'(dout_valid), 32'd1);
        do_start();
        check_eq("t5_valid_after_abort", 32'(dout_valid), 32'd0);
        fork
            drive_bursts(4, 600, 8, 0);
            consume(NFFT + 50, 1200, 128, 256, 1'b0);
        join

        // 6: asynchronous reset mid-READ
        check_eq("t6_busy_before_rst", 32'(busy), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("t6_async_reset", all_outputs(), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | dout_valid | busy;
        end
        check_eq("t6_idle_after_release", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
